// File: rtl/idu_decode_queue_if.sv
// Fetch-side and CU-side handshakes of the decode queue, bundled for port connection.
// The slave modport is the queue itself; the master modport is the surrounding fetch/CU logic.
interface idu_decode_queue_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic [31:0]      in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       Instruction_to_CU;
  logic [31:0]      imm;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       shamt;
  logic [31:0]      pc_increment;
  logic [31:0]      out_pc;
  logic             invalid_instruction;
  logic [CNT_W-1:0] invalid_count;

  modport master (
    output in_valid, instruction, in_pc, out_ready,
    input  in_ready, out_valid, Instruction_to_CU, imm, rd, rs1, rs2, shamt,
           pc_increment, out_pc, invalid_instruction, invalid_count
  );

  modport slave (
    input  in_valid, instruction, in_pc, out_ready,
    output in_ready, out_valid, Instruction_to_CU, imm, rd, rs1, rs2, shamt,
           pc_increment, out_pc, invalid_instruction, invalid_count
  );
endinterface

// File: rtl/idu_decode_queue.sv
// RV32I(+M) decoder fed by a small {instruction, pc} FIFO; one decode per clock into a
// registered output stage with valid/ready handshakes on both sides.
module idu_decode_queue #(
  parameter int QDEPTH    = 4,
  parameter int EN_M      = 0,
  parameter int EN_FENCEI = 1,
  parameter int CNT_W     = 16
) (
  input  logic                soc_clk,
  input  logic                IDU_reset_n,
  input  logic                flush,
  idu_decode_queue_if.slave   bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [5:0]       CODE_INVALID = 6'd63;

  logic [63:0]      mem [QDEPTH];
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic             full, empty, push, load;

  logic             out_valid_reg;
  logic [5:0]       code_reg;
  logic [31:0]      imm_reg, pc_inc_reg, out_pc_reg;
  logic [4:0]       rd_reg, rs1_reg, rs2_reg, shamt_reg;
  logic             invalid_reg;
  logic [CNT_W-1:0] count_reg;

  logic [31:0]      head_instr, head_pc;
  logic [6:0]       opcode, funct7;
  logic [2:0]       funct3;
  logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j;
  logic             dec_ok;
  logic [5:0]       code_next;
  logic [31:0]      imm_next, pc_inc_next;
  logic [4:0]       rd_next, rs1_next, rs2_next, shamt_next;

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign push  = bus.in_valid && !full;
  assign load  = !empty && (!out_valid_reg || bus.out_ready);

  always_ff @(posedge soc_clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg[AW-1:0]] <= {bus.instruction, bus.in_pc};
    end
  end

  assign {head_instr, head_pc} = mem[rd_ptr_reg[AW-1:0]];

  assign opcode = head_instr[6:0];
  assign funct3 = head_instr[14:12];
  assign funct7 = head_instr[31:25];
  assign imm_i  = {{20{head_instr[31]}}, head_instr[31:20]};
  assign imm_s  = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
  assign imm_b  = {{19{head_instr[31]}}, head_instr[31], head_instr[7], head_instr[30:25],
                   head_instr[11:8], 1'b0};
  assign imm_u  = {head_instr[31:12], 12'b0};
  assign imm_j  = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12], head_instr[20],
                   head_instr[30:21], 1'b0};

  always_comb begin
    dec_ok      = 1'b0;
    code_next   = CODE_INVALID;
    imm_next    = 32'd0;
    rd_next     = 5'd0;
    rs1_next    = 5'd0;
    rs2_next    = 5'd0;
    shamt_next  = 5'd0;
    pc_inc_next = 32'd4;
    case (opcode)
      7'b0110111: begin
        dec_ok = 1'b1; code_next = 6'd0; rd_next = head_instr[11:7]; imm_next = imm_u;
      end
      7'b0010111: begin
        dec_ok = 1'b1; code_next = 6'd1; rd_next = head_instr[11:7]; imm_next = imm_u;
      end
      7'b1101111: begin
        dec_ok = 1'b1; code_next = 6'd2; rd_next = head_instr[11:7]; pc_inc_next = imm_j;
      end
      7'b1100111: begin
        dec_ok    = (funct3 == 3'b000);
        code_next = 6'd3;
        rd_next   = head_instr[11:7]; rs1_next = head_instr[19:15]; imm_next = imm_i;
      end
      7'b1100011: begin
        // beq/bne at 4/5, blt..bgeu at 6..9; funct3 010/011 are unassigned
        dec_ok    = funct3[2] || !funct3[1];
        code_next = funct3[2] ? (6'd6 + {4'd0, funct3[1:0]}) : (6'd4 + {5'd0, funct3[0]});
        rs1_next  = head_instr[19:15]; rs2_next = head_instr[24:20]; imm_next = imm_b;
      end
      7'b0100011: begin
        dec_ok    = (funct3 < 3'd3);
        code_next = 6'd10 + {3'd0, funct3};
        rs1_next  = head_instr[19:15]; rs2_next = head_instr[24:20]; imm_next = imm_s;
      end
      7'b0000011: begin
        dec_ok    = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        code_next = funct3[2] ? (6'd16 + {5'd0, funct3[0]}) : (6'd13 + {4'd0, funct3[1:0]});
        rd_next   = head_instr[11:7]; rs1_next = head_instr[19:15]; imm_next = imm_i;
      end
      7'b0010011: begin
        rd_next  = head_instr[11:7];
        rs1_next = head_instr[19:15];
        case (funct3)
          3'b000: begin dec_ok = 1'b1; code_next = 6'd18; imm_next = imm_i; end
          3'b010: begin dec_ok = 1'b1; code_next = 6'd19; imm_next = imm_i; end
          3'b011: begin dec_ok = 1'b1; code_next = 6'd20; imm_next = imm_i; end
          3'b100: begin dec_ok = 1'b1; code_next = 6'd21; imm_next = imm_i; end
          3'b110: begin dec_ok = 1'b1; code_next = 6'd22; imm_next = imm_i; end
          3'b111: begin dec_ok = 1'b1; code_next = 6'd23; imm_next = imm_i; end
          3'b001: begin
            dec_ok = (funct7 == 7'b0000000); code_next = 6'd24; shamt_next = head_instr[24:20];
          end
          default: begin
            dec_ok     = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            code_next  = funct7[5] ? 6'd26 : 6'd25;
            shamt_next = head_instr[24:20];
          end
        endcase
      end
      7'b0110011: begin
        rd_next  = head_instr[11:7];
        rs1_next = head_instr[19:15];
        rs2_next = head_instr[24:20];
        if (funct7 == 7'b0000000) begin
          dec_ok = 1'b1;
          case (funct3)
            3'b000:  code_next = 6'd27;
            3'b001:  code_next = 6'd29;
            3'b010:  code_next = 6'd30;
            3'b011:  code_next = 6'd31;
            3'b100:  code_next = 6'd32;
            3'b101:  code_next = 6'd33;
            3'b110:  code_next = 6'd35;
            default: code_next = 6'd36;
          endcase
        end else if (funct7 == 7'b0100000) begin
          dec_ok    = (funct3 == 3'b000) || (funct3 == 3'b101);
          code_next = (funct3 == 3'b000) ? 6'd28 : 6'd34;
        end else if (funct7 == 7'b0000001 && EN_M != 0) begin
          dec_ok    = 1'b1;
          code_next = 6'd41 + {3'd0, funct3};
        end
      end
      7'b0001111: begin
        dec_ok    = (funct3 == 3'b000) || (funct3 == 3'b001 && EN_FENCEI != 0);
        code_next = funct3[0] ? 6'd38 : 6'd37;
      end
      7'b1110011: begin
        dec_ok    = (funct3 == 3'b000) && (head_instr[31:21] == 11'd0);
        code_next = head_instr[20] ? 6'd40 : 6'd39;
      end
      default: dec_ok = 1'b0;
    endcase
    if (!dec_ok) begin
      code_next   = CODE_INVALID;
      imm_next    = 32'd0;
      rd_next     = 5'd0;
      rs1_next    = 5'd0;
      rs2_next    = 5'd0;
      shamt_next  = 5'd0;
      pc_inc_next = 32'd4;
    end
  end

  always_ff @(posedge soc_clk or negedge IDU_reset_n) begin
    if (!IDU_reset_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      code_reg      <= 6'd0;
      imm_reg       <= 32'd0;
      rd_reg        <= 5'd0;
      rs1_reg       <= 5'd0;
      rs2_reg       <= 5'd0;
      shamt_reg     <= 5'd0;
      pc_inc_reg    <= 32'd4;
      out_pc_reg    <= 32'd0;
      invalid_reg   <= 1'b0;
      count_reg     <= '0;
    end else if (flush) begin
      // Data outputs and the illegal-instruction counter survive a flush.
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (load) begin
        rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
        out_valid_reg <= 1'b1;
        code_reg      <= code_next;
        imm_reg       <= imm_next;
        rd_reg        <= rd_next;
        rs1_reg       <= rs1_next;
        rs2_reg       <= rs2_next;
        shamt_reg     <= shamt_next;
        pc_inc_reg    <= pc_inc_next;
        out_pc_reg    <= head_pc;
        invalid_reg   <= !dec_ok;
        if (!dec_ok && count_reg != '1) begin
          count_reg <= count_reg + CNT_ONE;
        end
      end else if (out_valid_reg && bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready            = !full;
  assign bus.out_valid           = out_valid_reg;
  assign bus.Instruction_to_CU   = code_reg;
  assign bus.imm                 = imm_reg;
  assign bus.rd                  = rd_reg;
  assign bus.rs1                 = rs1_reg;
  assign bus.rs2                 = rs2_reg;
  assign bus.shamt               = shamt_reg;
  assign bus.pc_increment        = pc_inc_reg;
  assign bus.out_pc              = out_pc_reg;
  assign bus.invalid_instruction = invalid_reg;
  assign bus.invalid_count       = count_reg;
endmodule

// File: tb/tb_idu_decode_queue.sv
// Directed bench: an EN_M=0 queue with a 2-bit counter and an EN_M=1 twin on identical inputs.
module tb_idu_decode_queue;
  logic soc_clk = 1'b0;
  logic IDU_reset_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 soc_clk = ~soc_clk;

  idu_decode_queue_if #(.CNT_W(2))  bus ();
  idu_decode_queue_if #(.CNT_W(16)) busm ();

  assign busm.in_valid    = bus.in_valid;
  assign busm.instruction = bus.instruction;
  assign busm.in_pc       = bus.in_pc;
  assign busm.out_ready   = bus.out_ready;

  idu_decode_queue #(.QDEPTH(4), .EN_M(0), .EN_FENCEI(1), .CNT_W(2)) dut (
    .soc_clk(soc_clk), .IDU_reset_n(IDU_reset_n), .flush(flush), .bus(bus.slave)
  );

  idu_decode_queue #(.QDEPTH(4), .EN_M(1), .EN_FENCEI(1), .CNT_W(16)) dut_m (
    .soc_clk(soc_clk), .IDU_reset_n(IDU_reset_n), .flush(flush), .bus(busm.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge soc_clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] word, input logic [31:0] pc);
    bus.in_valid    = 1'b1;
    bus.instruction = word;
    bus.in_pc       = pc;
    step();
    bus.in_valid    = 1'b0;
  endtask

  // word, code, imm, rd, rs1, rs2, shamt
  logic [31:0] tbl_word  [7] = '{32'h123453B7, 32'hFE208EE3, 32'h0020A423, 32'h40208033,
                                 32'h4010D093, 32'h00100073, 32'hFFE1D203};
  logic [5:0]  tbl_code  [7] = '{6'd0, 6'd4, 6'd12, 6'd28, 6'd26, 6'd40, 6'd17};
  logic [31:0] tbl_imm   [7] = '{32'h12345000, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFE};
  logic [4:0]  tbl_rd    [7] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd4};
  logic [4:0]  tbl_rs1   [7] = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd1, 5'd0, 5'd3};
  logic [4:0]  tbl_rs2   [7] = '{5'd0, 5'd2, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0};
  logic [4:0]  tbl_shamt [7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0};

  logic [31:0] bad_word  [4] = '{32'hFFFFFFFF, 32'h40109093, 32'h00001073, 32'h00200073};
  logic [1:0]  bad_count [4] = '{2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.instruction = 32'd0;
    bus.in_pc       = 32'd0;
    bus.out_ready   = 1'b1;

    // Reset state
    step(); step();
    chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_code",      {26'd0, bus.Instruction_to_CU}, 32'd0);
    chk("rst_pc_inc",    bus.pc_increment, 32'd4);
    chk("rst_count",     {30'd0, bus.invalid_count}, 32'd0);
    IDU_reset_n = 1'b1;
    step();

    // addi x5,x1,-1: one-cycle latency, then drains with out_ready high
    push_one(32'hFFF08293, 32'h100);
    chk("addi_latency_valid", {31'd0, bus.out_valid}, 32'd0);
    step();
    chk("addi_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("addi_code",  {26'd0, bus.Instruction_to_CU}, 32'd18);
    chk("addi_rd",    {27'd0, bus.rd}, 32'd5);
    chk("addi_rs1",   {27'd0, bus.rs1}, 32'd1);
    chk("addi_imm",   bus.imm, 32'hFFFFFFFF);
    chk("addi_pc",    bus.out_pc, 32'h100);
    chk("addi_pc_inc", bus.pc_increment, 32'd4);
    step();
    chk("addi_drain_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("addi_hold_code",   {26'd0, bus.Instruction_to_CU}, 32'd18);

    // JAL x1,+2048
    push_one(32'h001000EF, 32'h104);
    step();
    chk("jal_code",   {26'd0, bus.Instruction_to_CU}, 32'd2);
    chk("jal_rd",     {27'd0, bus.rd}, 32'd1);
    chk("jal_imm",    bus.imm, 32'd0);
    chk("jal_pc_inc", bus.pc_increment, 32'h800);
    step();

    // Backpressure: stage + 4 FIFO entries, then a sixth word that must be refused
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bus.instruction = (k << 20) | (k << 7) | 32'h13;
      bus.in_pc       = 32'h200 + 32'(4 * (k - 1));
      step();
      if (k == 4) chk("bp_ready_k4", {31'd0, bus.in_ready}, 32'd1);
    end
    chk("bp_full_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_frozen_rd",  {27'd0, bus.rd}, 32'd1);
    bus.instruction = (32'd6 << 20) | (32'd6 << 7) | 32'h13;
    bus.in_pc       = 32'h214;
    step();
    chk("bp_still_full", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_frozen_imm", bus.imm, 32'd1);
    chk("bp_frozen_pc",  bus.out_pc, 32'h200);
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      chk("bp_drain_rd", {27'd0, bus.rd}, 32'(k));
      chk("bp_drain_pc", bus.out_pc, 32'h200 + 32'(4 * (k - 1)));
      step();
    end
    chk("bp_no_sixth", {31'd0, bus.out_valid}, 32'd0);

    // mul x3,x1,x2 on both variants
    push_one(32'h022081B3, 32'h300);
    step();
    chk("mul_m0_code",    {26'd0, bus.Instruction_to_CU}, 32'd63);
    chk("mul_m0_invalid", {31'd0, bus.invalid_instruction}, 32'd1);
    chk("mul_m0_rd",      {27'd0, bus.rd}, 32'd0);
    chk("mul_m0_count",   {30'd0, bus.invalid_count}, 32'd1);
    chk("mul_m1_code",    {26'd0, busm.Instruction_to_CU}, 32'd41);
    chk("mul_m1_rd",      {27'd0, busm.rd}, 32'd3);
    chk("mul_m1_rs2",     {27'd0, busm.rs2}, 32'd2);
    chk("mul_m1_count",   {16'd0, busm.invalid_count}, 32'd0);
    step();

    // Assorted legal encodings
    for (int t = 0; t < 7; t++) begin
      push_one(tbl_word[t], 32'h400 + 32'(4 * t));
      step();
      chk("tbl_code",    {26'd0, bus.Instruction_to_CU}, {26'd0, tbl_code[t]});
      chk("tbl_imm",     bus.imm, tbl_imm[t]);
      chk("tbl_rd",      {27'd0, bus.rd}, {27'd0, tbl_rd[t]});
      chk("tbl_rs1",     {27'd0, bus.rs1}, {27'd0, tbl_rs1[t]});
      chk("tbl_rs2",     {27'd0, bus.rs2}, {27'd0, tbl_rs2[t]});
      chk("tbl_shamt",   {27'd0, bus.shamt}, {27'd0, tbl_shamt[t]});
      chk("tbl_pc_inc",  bus.pc_increment, 32'd4);
      chk("tbl_invalid", {31'd0, bus.invalid_instruction}, 32'd0);
    end

    // Illegal encodings; 2-bit counter saturates at 3
    for (int t = 0; t < 4; t++) begin
      push_one(bad_word[t], 32'h500 + 32'(4 * t));
      step();
      chk("bad_code",    {26'd0, bus.Instruction_to_CU}, 32'd63);
      chk("bad_invalid", {31'd0, bus.invalid_instruction}, 32'd1);
      chk("bad_rd",      {27'd0, bus.rd}, 32'd0);
      chk("bad_shamt",   {27'd0, bus.shamt}, 32'd0);
      chk("bad_count",   {30'd0, bus.invalid_count}, {30'd0, bad_count[t]});
    end
    step();

    // Flush with stage + 2 FIFO entries occupied and a fresh word presented
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.instruction = 32'h00000013 | (32'(k + 1) << 7);
      bus.in_pc       = 32'h600 + 32'(4 * k);
      step();
    end
    chk("fl_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.instruction = 32'h00700393;
    bus.in_pc       = 32'h60C;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    chk("fl_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("fl_count", {30'd0, bus.invalid_count}, 32'd3);
    bus.out_ready = 1'b1;
    step(); step(); step();
    chk("fl_nothing_emerges", {31'd0, bus.out_valid}, 32'd0);

    // Asynchronous reset mid-burst
    bus.in_valid    = 1'b1;
    bus.instruction = 32'hFFF08293;
    bus.in_pc       = 32'h700;
    step();
    bus.instruction = 32'h001000EF;
    bus.in_pc       = 32'h704;
    step();
    bus.instruction = 32'hFFF08293;
    bus.in_pc       = 32'h708;
    step();
    chk("ar_pre_pc_inc", bus.pc_increment, 32'h800);
    #2;
    IDU_reset_n  = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("ar_valid",  {31'd0, bus.out_valid}, 32'd0);
    chk("ar_pc_inc", bus.pc_increment, 32'd4);
    chk("ar_code",   {26'd0, bus.Instruction_to_CU}, 32'd0);
    chk("ar_out_pc", bus.out_pc, 32'd0);
    chk("ar_count",  {30'd0, bus.invalid_count}, 32'd0);
    chk("ar_ready",  {31'd0, bus.in_ready}, 32'd1);
    step();
    IDU_reset_n = 1'b1;
    step();
    push_one(32'hFFF08293, 32'h800);
    step();
    chk("ar_restart_pc",   bus.out_pc, 32'h800);
    chk("ar_restart_code", {26'd0, bus.Instruction_to_CU}, 32'd18);
    step();
    chk("ar_no_stale", {31'd0, bus.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
